writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage: registers MEM-stage results (MEM/WB register), selects ALU vs load data,
//  and drives the register-file write port (write_enable/write_data/write_address) for one cycle
//  per retiring instruction. Also exports a forwarding tap and a halt state machine.
// PARAMETERS
//  DATA_WIDTH     16  width of register data
//  ADDR_WIDTH      3  register index width (2**ADDR_WIDTH registers, no hard-wired zero reg)
// PORTS
//  clk              in   1           clock, all state updates on posedge
//  rst              in   1           asynchronous, active-high reset
//  mem_valid        in   1           MEM stage presents an instruction
//  wb_ready         out  1           stage accepts; transfer when mem_valid && wb_ready
//  mem_reg_write    in   1           instruction writes a register
//  mem_to_reg       in   1           1: write mem_read_data, 0: write mem_alu_result
//  mem_halt         in   1           instruction is HLT
//  mem_dest         in   ADDR_WIDTH  destination register index
//  mem_alu_result   in   DATA_WIDTH  ALU result
//  mem_read_data    in   DATA_WIDTH  load data
//  stall            in   1           hazard unit: refuse new instruction this cycle
//  flush            in   1           discard the instruction offered this cycle
//  write_enable     out  1           register-file write strobe
//  write_address    out  ADDR_WIDTH  register-file write index
//  write_data       out  DATA_WIDTH  register-file write data
//  fwd_valid        out  1           forwarding tap valid (== write_enable)
//  fwd_address      out  ADDR_WIDTH  == write_address
//  fwd_data         out  DATA_WIDTH  == write_data
//  halted           out  1           HLT has retired
//  retire_count     out  16          retired-instruction count (only with WB_RETIRE_COUNT_EN)
// BEHAVIOUR
//  - Reset (async, immediate): state=RUN; write_enable=0, write_address=0, write_data=0,
//    halted=0, retire_count=0; all internal registers cleared.
//  - wb_ready = (state==RUN) && !stall (combinational).
//  - Accept at posedge when mem_valid && wb_ready && !flush: register loads dest, selected data
//    (mem_to_reg ? mem_read_data : mem_alu_result), write_enable <= mem_reg_write.
//  - Otherwise register loads a bubble: write_enable <= 0; address/data hold previous values.
//  - Latency: accepted at edge N -> write port driven for exactly cycle N..N+1, one cycle only.
//    Register file is level-sensitive; write_enable must never stay high two cycles for one instr.
//  - WB never stalls: the instruction already in the register always completes; stall only
//    blocks acceptance. flush has priority over accept; flush with stall = bubble.
//  - FSM: RUN -> HALTED on accepted instr with mem_halt=1 (its reg write, if any, still occurs).
//    HALTED: wb_ready=0, halted=1, bubbles only; exit only via rst. Flushed HLT is ignored.
//  - Back-to-back writes to the same dest: each gets its own one-cycle strobe, last wins.
//  - Reset mid-operation: pending write dropped, write_enable falls asynchronously.
// CONFIGURATION
//  WB_RETIRE_COUNT_EN defined: retire_count increments by 1 per accepted instruction (reg_write
//    or not, incl. HLT), wraps 0xFFFF->0x0000, never counts bubbles/flushed entries.
//  Undefined: counter and retire_count port absent; no other behavioural change.
// STRUCTURE
//  - Shared package pipeline_pkg: DATA_WIDTH/ADDR_WIDTH defaults, wb_state_t {WB_RUN, WB_HALTED}.
//  - Sub-module retire_counter (16-bit wrapping counter, clk/rst/inc), instantiated only under
//    WB_RETIRE_COUNT_EN; mux, MEM/WB register and FSM stay inline.
// TESTING
//  1 ALU write: dest=3, alu=0x1234, mem_to_reg=0 -> next cycle write_enable=1, addr=3,
//    data=0x1234 for exactly one cycle; fwd_* identical.
//  2 Load: mem_to_reg=1, read_data=0xBEEF, alu=0x0001, dest=5 -> write_data=0xBEEF, addr=5.
//  3 Stall: stall=1 with valid instr -> wb_ready=0, next cycle write_enable=0; instr in WB
//    before stall still writes; release stall -> instr accepted, one strobe.
//  4 Flush+accept same cycle (dest=2, alu=0x00FF) -> no write; retire_count unchanged.
//  5 HLT with reg_write=1 dest=7 -> write to r7 once, then halted=1, wb_ready=0 despite
//    mem_valid; rst -> halted=0, wb_ready=1.
//  6 Async rst asserted mid-cycle while write_enable=1 -> write_enable=0 before next edge;
//    with WB_RETIRE_COUNT_EN, 65536 accepts from reset -> retire_count=0x0000.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default data/register-index widths and the writeback FSM states.
package pipeline_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_t;
endpackage

// File: rtl/retire_counter.sv
// 16-bit wrapping retired-instruction counter; advances by one on every cycle inc is high.
module retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, ALU/load select, one-cycle register-file strobe, halt FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  wb_ready,
  input  logic                  mem_reg_write,
  input  logic                  mem_to_reg,
  input  logic                  mem_halt,
  input  logic [ADDR_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_address,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  halted
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [15:0]           retire_count
`endif
);
  wb_state_t             state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;

  assign wb_ready = (state_q == WB_RUN) && !stall;
  assign accept   = mem_valid && wb_ready && !flush;

  // Bubbles clear only the strobe; address/data hold so the port does not toggle needlessly.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      we_d   = mem_reg_write;
      addr_d = mem_dest;
      data_d = mem_to_reg ? mem_read_data : mem_alu_result;
      if (mem_halt) state_d = WB_HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_RUN;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign fwd_valid     = we_q;
  assign fwd_address   = addr_q;
  assign fwd_data      = data_q;
  assign halted        = (state_q == WB_HALTED);

`ifdef WB_RETIRE_COUNT_EN
  retire_counter u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (retire_count)
  );
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_reg_write = 1'b0, mem_to_reg = 1'b0, mem_halt = 1'b0;
  logic [2:0]  mem_dest = '0;
  logic [15:0] mem_alu_result = '0, mem_read_data = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        wb_ready, write_enable, fwd_valid, halted;
  logic [2:0]  write_address, fwd_address;
  logic [15:0] write_data, fwd_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: what the register-file port should show after the most recent edge.
  logic        m_we = 1'b0, m_halted = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  int unsigned m_cnt = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .wb_ready(wb_ready),
    .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg), .mem_halt(mem_halt),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .stall(stall), .flush(flush), .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .fwd_valid(fwd_valid), .fwd_address(fwd_address),
    .fwd_data(fwd_data), .halted(halted)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  function automatic logic [41:0] obs();
    return {write_enable, write_address, write_data, fwd_valid, fwd_address, fwd_data,
            halted, wb_ready};
  endfunction

  function automatic logic [41:0] expv();
    return {m_we, m_addr, m_data, m_we, m_addr, m_data, m_halted, (!m_halted && !stall)};
  endfunction

  task automatic model_reset();
    m_we = 1'b0; m_halted = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
  endtask

  // Drives one offered instruction, advances one edge, updates the model, returns #1 after the edge.
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic hl,
                       input logic [2:0] d, input logic [15:0] alu, input logic [15:0] rd,
                       input logic st, input logic fl);
    logic acc;
    mem_valid = v; mem_reg_write = rw; mem_to_reg = m2r; mem_halt = hl; mem_dest = d;
    mem_alu_result = alu; mem_read_data = rd; stall = st; flush = fl;
    acc = v && !m_halted && !st && !fl;
    @(posedge clk);
    if (acc) begin
      m_we = rw; m_addr = d; m_data = m2r ? rd : alu; m_cnt = m_cnt + 1;
      if (hl) m_halted = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    #1;
    $display("txn v=%0b rw=%0b m2r=%0b hlt=%0b dest=%0d alu=%h rd=%h stall=%0b flush=%0b -> we=%0b addr=%0d data=%h halted=%0b",
             v, rw, m2r, hl, d, alu, rd, st, fl, write_enable, write_address, write_data, halted);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_valid = 1'b1;
    #3;
    model_reset();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL reset_state actual=%h required=%h", obs(), expv());
    end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (retire_count !== 16'h0) begin
      failures++; $display("FAIL reset_count actual=%h required=0000", retire_count);
    end
`endif
    @(negedge clk);
    mem_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h5555, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || write_data !== 16'h1234 || write_address !== 3'd3 || write_enable !== 1'b1) begin
      failures++; $display("FAIL alu_write actual=%h required=%h", obs(), expv());
    end
    idle();
    checks++;
    if (write_enable !== 1'b0 || fwd_valid !== 1'b0) begin
      failures++; $display("FAIL alu_one_cycle actual we=%b fwd=%b required 0", write_enable, fwd_valid);
    end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h0001, 16'hBEEF, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || write_data !== 16'hBEEF || write_address !== 3'd5) begin
      failures++; $display("FAIL load_write actual=%h required=%h", obs(), expv());
    end
    idle();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'hA001, 16'h0, 1'b0, 1'b0);
    mem_valid = 1'b1; stall = 1'b1;
    #1;
    checks++;
    if (wb_ready !== 1'b0 || write_enable !== 1'b1 || write_data !== 16'hA001) begin
      failures++; $display("FAIL stall_ready actual ready=%b we=%b data=%h required ready=0 we=1 data=a001",
                           wb_ready, write_enable, write_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'hB002, 16'h0, 1'b1, 1'b0);
    checks++;
    if (obs() !== expv() || write_enable !== 1'b0) begin
      failures++; $display("FAIL stall_bubble actual=%h required=%h", obs(), expv());
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'hB002, 16'h0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || write_data !== 16'hB002) begin
      failures++; $display("FAIL stall_release actual=%h required=%h", obs(), expv());
    end
    idle();
    checks++;
    if (write_enable !== 1'b0) begin
      failures++; $display("FAIL stall_one_strobe actual we=%b required 0", write_enable);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h00FF, 16'h0, 1'b0, 1'b1);
    checks++;
    if (obs() !== expv() || write_enable !== 1'b0) begin
      failures++; $display("FAIL flush_no_write actual=%h required=%h", obs(), expv());
    end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (retire_count !== m_cnt[15:0]) begin
      failures++; $display("FAIL flush_count actual=%h required=%h", retire_count, m_cnt[15:0]);
    end
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 16'h0DEF, 16'h0, 1'b1, 1'b1);
    checks++;
    if (obs() !== expv() || halted !== 1'b0) begin
      failures++; $display("FAIL flush_stall_hlt actual=%h required=%h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'h1111, 16'h0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL b2b_first actual=%h required=%h", obs(), expv());
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'h2222, 16'h0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || write_data !== 16'h2222 || write_enable !== 1'b1) begin
      failures++; $display("FAIL b2b_second actual=%h required=%h", obs(), expv());
    end
    idle();
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h7777, 16'h0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || write_address !== 3'd7 || halted !== 1'b1) begin
      failures++; $display("FAIL halt_write actual=%h required=%h", obs(), expv());
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h9999, 16'h0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv() || wb_ready !== 1'b0 || write_enable !== 1'b0) begin
      failures++; $display("FAIL halt_blocks actual=%h required=%h", obs(), expv());
    end
    do_reset();
    mem_valid = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || wb_ready !== 1'b1) begin
      failures++; $display("FAIL halt_reset actual halted=%b ready=%b required halted=0 ready=1", halted, wb_ready);
    end
    idle();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'hCAFE, 16'h0, 1'b0, 1'b0);
    mem_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs() !== expv() || write_enable !== 1'b0) begin
      failures++; $display("FAIL async_reset actual=%h required=%h", obs(), expv());
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
            16'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random_%0d actual=%h required=%h", i, obs(), expv());
      end
`ifdef WB_RETIRE_COUNT_EN
      checks++;
      if (retire_count !== m_cnt[15:0]) begin
        failures++; $display("FAIL random_count_%0d actual=%h required=%h", i, retire_count, m_cnt[15:0]);
      end
`endif
      if (m_halted) do_reset();
    end
    idle();
  endtask

`ifdef WB_RETIRE_COUNT_EN
  task automatic test_count_wrap();
    do_reset();
    mem_valid = 1'b1; mem_reg_write = 1'b0; mem_halt = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    checks++;
    if (retire_count !== 16'hFFFF) begin
      failures++; $display("FAIL count_ffff actual=%h required=ffff", retire_count);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    checks++;
    if (retire_count !== 16'h0000) begin
      failures++; $display("FAIL count_wrap actual=%h required=0000", retire_count);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_write();
    test_load();
    test_stall();
    test_flush();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_random();
`ifdef WB_RETIRE_COUNT_EN
    test_count_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
